// File: rtl/minesweeper_board.sv
// ---------------------------------------------------------------------------
// minesweeper_board
//
// Board datapath that sits under the game control FSM. It keeps the cursor
// position, the bomb layout (placed pseudo-randomly from a free-running
// Galois LFSR) and the map of revealed cells, and reports the win/lose code
// the controller branches on.
//
// Ports
//   clock       in   1  system clock, all state on rising edge
//   reset       in   1  synchronous, active-low
//   init        in   1  pulse: clear the board and start bomb placement
//   move        in   1  pulse: step the cursor one cell in dir
//   dir         in   2  00 up, 01 down, 10 left, 11 right
//   reveal      in   1  pulse: reveal the cell under the cursor
//   busy        out  1  high while bombs are being placed
//   wl          out  2  00 playing/idle, 01 win, 10 lose
//   nbr_count   out  4  bombs in the 8-neighbourhood of the cursor cell
//   bombGrid    out  N  bit i = bomb at cell i (i = row*GRID_SIZE + col)
//   revealGrid  out  N  bit i = cell i revealed
//   cursorGrid  out  N  one-hot cursor position
// ---------------------------------------------------------------------------
module minesweeper_board #(
    parameter int          GRID_SIZE  = 3,
    parameter int          BOMB_COUNT = 2,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             init,
    input  logic                             move,
    input  logic [1:0]                       dir,
    input  logic                             reveal,
    output logic                             busy,
    output logic [1:0]                       wl,
    output logic [3:0]                       nbr_count,
    output logic [GRID_SIZE*GRID_SIZE-1:0]   bombGrid,
    output logic [GRID_SIZE*GRID_SIZE-1:0]   revealGrid,
    output logic [GRID_SIZE*GRID_SIZE-1:0]   cursorGrid
);

    localparam int N    = GRID_SIZE * GRID_SIZE;
    localparam int IDXW = $clog2(N);
    localparam int CW   = $clog2(GRID_SIZE);
    localparam int CNTW = $clog2(BOMB_COUNT + 1);

    localparam logic [N-1:0]    ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   MAX_POS  = CW'(GRID_SIZE - 1);
    localparam logic [CNTW-1:0] TARGET   = CNTW'(BOMB_COUNT);
    localparam logic [15:0]     TAPS     = 16'hB400;

    localparam logic [1:0] WL_PLAY = 2'b00;
    localparam logic [1:0] WL_WIN  = 2'b01;
    localparam logic [1:0] WL_LOSE = 2'b10;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        PLACE,
        READY,
        DONE
    } state_t;

    state_t            state;
    logic [15:0]       lfsr;
    logic [15:0]       lfsr_next;
    logic [CW-1:0]     row;
    logic [CW-1:0]     col;
    logic [CNTW-1:0]   placed;

    logic [IDXW-1:0]   cursor_idx;
    logic [N-1:0]      cursor_bit;
    logic [N-1:0]      reveal_next;
    logic              hit_bomb;
    logic              already_open;
    logic              all_clear;

    logic [IDXW-1:0]   cand;
    logic [N-1:0]      cand_bit;
    logic              cand_free;

    int                nr;
    int                nc;

    // Galois step: shift right and fold the taps back in when a one falls
    // out of the bottom. A nonzero seed can never reach the all-zero state.
    assign lfsr_next = lfsr[0] ? ({1'b0, lfsr[15:1]} ^ TAPS) : {1'b0, lfsr[15:1]};

    // Cursor decode, shared by the one-hot output and the reveal logic.
    assign cursor_idx = IDXW'(int'(row) * GRID_SIZE + int'(col));
    assign cursor_bit = ONE_HOT0 << cursor_idx;
    assign cursorGrid = cursor_bit;

    // Reveal outcome for the cell under the cursor (pre-move position).
    assign reveal_next  = revealGrid | cursor_bit;
    assign hit_bomb     = |(bombGrid & cursor_bit);
    assign already_open = |(revealGrid & cursor_bit);
    assign all_clear    = &(reveal_next | bombGrid);

    // Placement candidate: the low LFSR bits name a cell; values past the
    // last cell, or cells already holding a bomb, are simply skipped and a
    // fresh candidate is tried next cycle.
    assign cand      = lfsr[IDXW-1:0];
    assign cand_bit  = ONE_HOT0 << cand;
    assign cand_free = (32'(cand) < N) && ((bombGrid & cand_bit) == '0);

    // Neighbour count around the cursor; off-board neighbours and the
    // cursor's own cell contribute nothing.
    always_comb begin
        nbr_count = 4'd0;
        nr        = 0;
        nc        = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                nr = int'(row) + dr;
                nc = int'(col) + dc;
                if ((dr != 0 || dc != 0) &&
                    nr >= 0 && nr < GRID_SIZE && nc >= 0 && nc < GRID_SIZE) begin
                    if (bombGrid[IDXW'(nr * GRID_SIZE + nc)]) begin
                        nbr_count = nbr_count + 4'd1;
                    end
                end
            end
        end
    end

    // Board state machine. init overrides everything else in any state and
    // drops a coincident move/reveal. In READY a reveal is evaluated on the
    // cursor position before any coincident move takes effect.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            lfsr       <= LFSR_SEED;
            row        <= '0;
            col        <= '0;
            placed     <= '0;
            bombGrid   <= '0;
            revealGrid <= '0;
            wl         <= WL_PLAY;
            busy       <= 1'b0;
        end else begin
            lfsr <= lfsr_next;
            if (init) begin
                state      <= PLACE;
                row        <= '0;
                col        <= '0;
                placed     <= '0;
                bombGrid   <= '0;
                revealGrid <= '0;
                wl         <= WL_PLAY;
                busy       <= 1'b1;
            end else begin
                case (state)
                    PLACE: begin
                        if (placed == TARGET) begin
                            state <= READY;
                            busy  <= 1'b0;
                        end else if (cand_free) begin
                            bombGrid <= bombGrid | cand_bit;
                            placed   <= placed + CNTW'(1);
                        end
                    end
                    READY: begin
                        if (reveal && !already_open) begin
                            revealGrid <= reveal_next;
                            if (hit_bomb) begin
                                wl    <= WL_LOSE;
                                state <= DONE;
                            end else if (all_clear) begin
                                wl    <= WL_WIN;
                                state <= DONE;
                            end
                        end
                        if (move) begin
                            case (dir)
                                DIR_UP:    if (row != '0)      row <= row - CW'(1);
                                DIR_DOWN:  if (row != MAX_POS) row <= row + CW'(1);
                                DIR_LEFT:  if (col != '0)      col <= col - CW'(1);
                                DIR_RIGHT: if (col != MAX_POS) col <= col + CW'(1);
                                default:   ;
                            endcase
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
